// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage.
//   Owns the PC and builds one 32-bit instruction from four byte reads on the
//   8-bit memory-controller port. The first byte read (at pc) ends up in
//   if_inst[31:24]. The IF/ID register does the little-endian swap.
//   stallreq_if is high while no complete instruction is held.
//   A branch flush redirects fetch to branch_target.
//
// Parameters:
//   RESET_PC      PC loaded at reset
//   ICACHE_LINES  lines in the optional I-cache (power of 2)
//
// Optional feature:
//   Define ICACHE_EN to add a direct-mapped, one-word-per-line I-cache.
//   A hit delivers the instruction one cycle after the lookup, with no memory
//   requests. The default build has no cache storage.
//
// Ports:
//   clk               clock, rising edge
//   rst               asynchronous reset, active low
//   stall[5:0]        pipeline stall vector; stall[1]=1 holds the IF/ID stage
//   flush_from_branch 1 = redirect fetch to branch_target
//   branch_target     redirect address, used verbatim
//   mem_req           byte read request (registered)
//   mem_addr          byte address of the request (registered)
//   mem_valid         mem_data is valid for the current mem_addr
//   mem_data          returned byte
//   if_pc, if_inst    held PC/instruction, zero when nothing is held
//   stallreq_if       1 = no complete instruction held
//   dbg_state         FSM state (0 = FETCH, 1 = HOLD)
//
// Handshake: a byte is accepted on a rising edge where mem_req and mem_valid
// are both high and no branch flush is present. mem_valid is ignored while
// mem_req is low.
module if_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          ICACHE_LINES = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush_from_branch,
  input  logic [31:0] branch_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [7:0]  mem_data,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if,
  output logic        dbg_state
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [1:0]  cnt, cnt_n;
  logic [31:0] word_q, word_n;
  logic        valid, valid_n;
  logic        accept;
  logic        fill;
  logic        hit_c;   // cache hit for the current pc (lookup cycle)
  logic        hit_n;   // cache hit for the next pc (decides next mem_req)
  logic [31:0] hit_word;

  // Stall bits other than the IF/ID hold bit are not used by this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5:2], stall[0]};

`ifdef ICACHE_EN
  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 30 - IDX_W;

  logic [31:0]       line_data [ICACHE_LINES];
  logic [TAG_W-1:0]  line_tag  [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] line_vld;
  logic [IDX_W-1:0]  idx_c, idx_n;

  assign idx_c    = pc[IDX_W+1:2];
  assign idx_n    = pc_n[IDX_W+1:2];
  assign hit_word = line_data[idx_c];
  assign hit_c    = (state == FETCH) && (cnt == 2'd0) && line_vld[idx_c] &&
                    (line_tag[idx_c] == pc[31:IDX_W+2]);
  assign hit_n    = (state_n == FETCH) && (cnt_n == 2'd0) && line_vld[idx_n] &&
                    (line_tag[idx_n] == pc_n[31:IDX_W+2]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_vld <= '0;
    end else if (fill) begin
      line_vld[idx_c] <= 1'b1;
    end
  end

  // Line data and tags only matter once the valid bit is set.
  always_ff @(posedge clk) begin
    if (fill) begin
      line_data[idx_c] <= word_n;
      line_tag[idx_c]  <= pc[31:IDX_W+2];
    end
  end
`else
  localparam int unused_lines = ICACHE_LINES;
  assign hit_c    = 1'b0;
  assign hit_n    = 1'b0;
  assign hit_word = 32'h0;
`endif

  assign accept = (state == FETCH) && mem_req && mem_valid;

  // Next-state logic. Branch beats cache hit, completion and consume.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    cnt_n   = cnt;
    word_n  = word_q;
    valid_n = valid;
    fill    = 1'b0;
    if (flush_from_branch) begin
      pc_n    = branch_target;
      cnt_n   = 2'd0;
      valid_n = 1'b0;
      state_n = FETCH;
    end else if (state == HOLD) begin
      if (!stall[1]) begin
        pc_n    = pc + 32'd4;
        valid_n = 1'b0;
        state_n = FETCH;
      end
    end else if (hit_c) begin
      word_n  = hit_word;
      valid_n = 1'b1;
      state_n = HOLD;
    end else if (accept) begin
      word_n = {word_q[23:0], mem_data};
      cnt_n  = cnt + 2'd1;
      if (cnt == 2'd3) begin
        valid_n = 1'b1;
        state_n = HOLD;
        fill    = 1'b1;
      end
    end
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      cnt      <= 2'd0;
      word_q   <= 32'h0;
      valid    <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0;
      if_pc    <= 32'h0;
      if_inst  <= 32'h0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      cnt      <= cnt_n;
      word_q   <= word_n;
      valid    <= valid_n;
      mem_req  <= (state_n == FETCH) && !hit_n;
      mem_addr <= (state_n == FETCH) ? (pc_n + {30'd0, cnt_n}) : 32'h0;
      if_pc    <= valid_n ? pc_n   : 32'h0;
      if_inst  <= valid_n ? word_n : 32'h0;
    end
  end

  assign stallreq_if = ~valid;
  assign dbg_state   = state;

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush_from_branch;
  logic [31:0] branch_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [7:0]  mem_data;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;
  logic        dbg_state;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  if_fetch dut (
    .clk(clk), .rst(rst), .stall(stall),
    .flush_from_branch(flush_from_branch), .branch_target(branch_target),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_data(mem_data),
    .if_pc(if_pc), .if_inst(if_inst), .stallreq_if(stallreq_if),
    .dbg_state(dbg_state)
  );

  // Memory model: fixed program bytes at 0..3, address hash elsewhere.
  function automatic logic [7:0] mb(input logic [31:0] a);
    case (a)
      32'd0:   mb = 8'h13;
      32'd1:   mb = 8'h05;
      32'd2:   mb = 8'h10;
      32'd3:   mb = 8'h00;
      default: mb = (a[7:0] * 8'd7) ^ a[31:24] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    word_at = {mb(a), mb(a + 32'd1), mb(a + 32'd2), mb(a + 32'd3)};
  endfunction

  assign mem_data = mb(mem_addr);

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, word_at(pc)});
  endtask

  task automatic wait_valid(input int budget, input bit rnd);
    int cycles;
    cycles = 0;
    while (stallreq_if !== 1'b0 && cycles < budget) begin
      if (rnd) mem_valid = 1'($urandom_range(0, 1));
      tick();
      cycles++;
    end
    mem_valid = 1'b1;
    if (stallreq_if !== 1'b0) check("wait_valid_timeout", {31'd0, stallreq_if}, 32'd0);
  endtask

  // scoreboard pop
  task automatic pop_check(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_stallreq"}, {31'd0, stallreq_if}, 32'd0);
      check({tag, "_pc"}, if_pc, e[63:32]);
      check({tag, "_inst"}, if_inst, e[31:0]);
    end
  endtask

  initial begin
    rst = 1'b0;
    stall = 6'd0;
    flush_from_branch = 1'b0;
    branch_target = 32'h0;
    mem_valid = 1'b0;

    // 1. reset held over 3 edges
    repeat (3) tick();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_inst", if_inst, 32'd0);
    check("rst_stallreq", {31'd0, stallreq_if}, 32'd1);

    // release; addresses 0..3 on consecutive cycles
    rst = 1'b1;
    mem_valid = 1'b1;
    push_exp(32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("seq_mem_req", {31'd0, mem_req}, 32'd1);
      check("seq_mem_addr", mem_addr, i);
      check("seq_stallreq", {31'd0, stallreq_if}, 32'd1);
    end
    // 2. fourth byte accepted on this edge
    tick();
    check("done_mem_req", {31'd0, mem_req}, 32'd0);
    check("first_word_const", if_inst, 32'h1305_1000);
    pop_check("first_fetch");

    // 4. stall hold for 5 cycles
    stall = 6'b000010;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_mem_req", {31'd0, mem_req}, 32'd0);
      check("hold_if_inst", if_inst, 32'h1305_1000);
      check("hold_stallreq", {31'd0, stallreq_if}, 32'd0);
    end
    stall = 6'd0;
    tick();
    check("consume_mem_addr", mem_addr, 32'h4);
    check("consume_stallreq", {31'd0, stallreq_if}, 32'd1);
    check("consume_if_pc", if_pc, 32'h0);

    // 3. wait states before byte 2
    push_exp(32'h4);
    tick();
    check("ws_addr5", mem_addr, 32'h5);
    tick();
    check("ws_addr6", mem_addr, 32'h6);
    mem_valid = 1'b0;
    tick();
    check("ws_hold6a", mem_addr, 32'h6);
    tick();
    check("ws_hold6b", mem_addr, 32'h6);
    mem_valid = 1'b1;
    tick();
    check("ws_addr7", mem_addr, 32'h7);
    tick();
    pop_check("wait_state_fetch");

    // 5. branch mid-fetch with cnt==2 and a live byte
    tick();
    check("pc8_addr", mem_addr, 32'h8);
    tick();
    tick();
    check("pre_branch_addr", mem_addr, 32'hA);
    flush_from_branch = 1'b1;
    branch_target = 32'h100;
    tick();
    flush_from_branch = 1'b0;
    check("br_mem_addr", mem_addr, 32'h100);
    check("br_mem_req", {31'd0, mem_req}, 32'd1);
    push_exp(32'h100);
    wait_valid(12, 1'b0);
    pop_check("branch_fetch");

    // branch in HOLD beats the stall hold; target near the top of memory
    flush_from_branch = 1'b1;
    branch_target = 32'hFFFF_FFFE;
    stall = 6'b000010;
    tick();
    flush_from_branch = 1'b0;
    stall = 6'd0;
    check("brhold_if_pc", if_pc, 32'h0);
    check("brhold_if_inst", if_inst, 32'h0);
    check("brhold_stallreq", {31'd0, stallreq_if}, 32'd1);
    check("wrap_addr0", mem_addr, 32'hFFFF_FFFE);
    push_exp(32'hFFFF_FFFE);
    tick();
    check("wrap_addr1", mem_addr, 32'hFFFF_FFFF);
    tick();
    check("wrap_addr2", mem_addr, 32'h0);
    wait_valid(12, 1'b0);
    pop_check("wrap_fetch");
    tick();
    check("wrap_pc_plus4", mem_addr, 32'h2);

    // branch beats completion at cnt==3
    tick();
    tick();
    tick();
    check("pre_cmpl_addr", mem_addr, 32'h5);
    flush_from_branch = 1'b1;
    branch_target = 32'h40;
    tick();
    flush_from_branch = 1'b0;
    check("br_cmpl_stallreq", {31'd0, stallreq_if}, 32'd1);
    check("br_cmpl_addr", mem_addr, 32'h40);
    push_exp(32'h40);
    wait_valid(80, 1'b1);
    pop_check("random_ws_fetch");

    // reset mid-fetch discards partial bytes
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    check("midrst_stallreq", {31'd0, stallreq_if}, 32'd1);
    tick();
    rst = 1'b1;
    push_exp(32'h0);
    tick();
    check("postrst_addr", mem_addr, 32'h0);
    wait_valid(12, 1'b0);
    pop_check("post_reset_fetch");

`ifdef ICACHE_EN
    // 6. miss then hit at the same address
    flush_from_branch = 1'b1;
    branch_target = 32'h100;
    tick();
    flush_from_branch = 1'b0;
    check("ic_miss_req", {31'd0, mem_req}, 32'd1);
    push_exp(32'h100);
    wait_valid(12, 1'b0);
    pop_check("ic_miss_fetch");
    flush_from_branch = 1'b1;
    tick();
    flush_from_branch = 1'b0;
    check("ic_hit_req", {31'd0, mem_req}, 32'd0);
    check("ic_hit_stallreq", {31'd0, stallreq_if}, 32'd1);
    push_exp(32'h100);
    tick();
    check("ic_hit_req2", {31'd0, mem_req}, 32'd0);
    pop_check("ic_hit_fetch");
`endif

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
